fetch_redirect: RTL and testbench
=================================

# fetch_redirect

IF/ID pipeline latch plus control-flow resolver for the 16-bit pipeline. It captures the instruction/PC pair from the fetch stage and resolves branches (1100), JAL (1101), JR (1110) and HLT (1111). It drives the redirect interface back into fetch (`PCSrc`, `bAddress`, `takeJump`, `jrValue`, `hlt`) and squashes the wrong-path instruction after every taken redirect. It stalls fetch while a branch waits for flags or a JR waits for its register operand.

## Interface
No parameters; data width is fixed at 16.
- `clk` in 1: single clock, all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `instr_in` in 16: instruction from fetch.
- `pc_in` in 16: PC of `instr_in`.
- `stall_in` in 1: downstream ID stall; hold IF/ID contents.
- `flags_valid` in 1: Z/N/V reflect all older flag-setting instructions.
- `zr`, `neg`, `ov` in 1 each: condition flags from EX.
- `jr_valid` in 1: `jr_data` holds the current value of the JR source register.
- `jr_data` in 16: JR target register value.
- `instr_out` out 16: IF/ID instruction to decode.
- `pc_out` out 16: IF/ID PC.
- `valid_out` out 1: `instr_out` is a real instruction, not a bubble.
- `fetch_stall` out 1: fetch must hold its PC.
- `PCSrc` out 1: take branch to `bAddress`.
- `bAddress` out 16: branch target.
- `takeJump` out 1: take jump to `jrValue`.
- `jrValue` out 16: jump target (JAL or JR).
- `hlt` out 1: stop fetch; sticky until reset.

## Operation
- **Reset** clears all of the following to 0:
  - `instr_out`, `pc_out`, `valid_out`, `fetch_stall`
  - `PCSrc`, `bAddress`, `takeJump`, `jrValue`, `hlt`
  - state is set to RUN.
- **States:** RUN, WAIT_FLAGS, WAIT_REG, SQUASH, HALTED.
- **RUN**
  - If `stall_in`=0, latch `instr_in`/`pc_in` with `valid_out`=1.
  - Then evaluate the latched opcode [15:12].
- **Branch (1100)**
  - Condition field [11:9]:
    - 000 !Z
    - 001 Z
    - 010 !Z&!N
    - 011 N
    - 100 Z|!N
    - 101 N|Z
    - 110 V
    - 111 always
  - Target = `pc_out`+1+sext([8:0]), mod 2^16.
  - `flags_valid`=0 (except cond 111): go to WAIT_FLAGS.
  - Resolved taken: `PCSrc`=1, `bAddress`=target.
  - Resolved not taken: no redirect.
- **JAL (1101)**
  - `takeJump`=1, `jrValue`=`pc_out`+1+zext([11:0]), mod 2^16.
- **JR (1110)**
  - `jr_valid`=0: go to WAIT_REG.
  - Otherwise `takeJump`=1, `jrValue`=`jr_data`.
- **HLT (1111)**
  - `hlt`=1 and go to HALTED.
  - The HLT instruction itself is presented with `valid_out`=1.
- **WAIT_FLAGS / WAIT_REG**
  - `fetch_stall`=1; the IF/ID register holds.
  - Resolve in the first cycle `flags_valid` / `jr_valid` is 1, then proceed as in RUN.
- **Taken redirect** (`PCSrc` or `takeJump` high for exactly one cycle)
  - The next state is SQUASH.
  - The instruction captured at that edge is wrong-path: latch it with `valid_out`=0.
  - Return to RUN next cycle.
- **HALTED**
  - Absorbing until `rst`.
  - `hlt`=1, `fetch_stall`=1.
  - `valid_out`=0 after the HLT cycle; no redirects.
- **`stall_in`=1** in any state: IF/ID holds and `fetch_stall`=1.
  - Redirect outputs stay 0 until `stall_in` drops; resolution happens in the first unstalled cycle.
- **Mutual exclusion:** `PCSrc` and `takeJump` are never both 1.
- **Non-control opcodes** pass through with no redirect.

## Timing
- IF/ID capture latency: 1 cycle from `instr_in` to `instr_out`.
- Redirect outputs are combinational from IF/ID state plus `flags_valid`/`zr`/`neg`/`ov`/`jr_valid`/`jr_data`; fetch samples them at the next posedge.
- Taken-redirect penalty: exactly 1 bubble (`valid_out`=0 for one cycle), then the target instruction appears.
- A redirect asserted in the same cycle as `rst` is ignored; reset wins.
- Reset mid-WAIT or mid-SQUASH returns to RUN with all outputs 0 on the next cycle.
- A branch with cond 111 never waits for `flags_valid`.

## Test plan
- **Reset:** hold `rst` 2 cycles with random inputs -> all outputs 0; `valid_out`=0.
- **Taken branch:** `pc_in`=0x0010, `instr_in`=0xC3F0 (cond 001, imm -16), `zr`=1, `flags_valid`=1 ->
  - `PCSrc`=1, `bAddress`=0x0001 for one cycle;
  - next cycle `valid_out`=0 (squash);
  - the following cycle shows the target instruction.
- **Flag wait:** same branch with `flags_valid`=0 for 3 cycles, `zr`=0 ->
  - `fetch_stall`=1 for 3 cycles, `instr_out` stable;
  - on `flags_valid`=1, no `PCSrc` and no squash.
- **JAL wraparound:** `pc_in`=0xFFF0, `instr_in`=0xD020 -> `takeJump`=1, `jrValue`=0x0011, then one bubble.
- **JR wait:** `instr_in`=0xE010, `jr_valid`=0 for 2 cycles then `jr_data`=0x1234 ->
  - `fetch_stall`=1 for 2 cycles;
  - then `takeJump`=1, `jrValue`=0x1234.
- **HLT then reset:**
  - HLT at `pc_in`=0x0020 -> `hlt`=1 and sticky; later `instr_in` ignored, `valid_out`=0.
  - `rst` pulse -> `hlt`=0 and normal capture resumes.

Source files
------------

// File: rtl/fetch_redirect.sv
// IF/ID pipeline latch with branch/JAL/JR/HLT resolution.
// Drives redirects back to fetch and squashes the wrong-path slot.
module fetch_redirect (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_in,
  input  logic [15:0] pc_in,
  input  logic        stall_in,
  input  logic        flags_valid,
  input  logic        zr,
  input  logic        neg,
  input  logic        ov,
  input  logic        jr_valid,
  input  logic [15:0] jr_data,
  output logic [15:0] instr_out,
  output logic [15:0] pc_out,
  output logic        valid_out,
  output logic        fetch_stall,
  output logic        PCSrc,
  output logic [15:0] bAddress,
  output logic        takeJump,
  output logic [15:0] jrValue,
  output logic        hlt
);

  typedef enum logic [2:0] {
    RUN,
    WAIT_FLAGS,
    WAIT_REG,
    SQUASH,
    HALTED
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_q, pc_d;
  logic        valid_q, valid_d;

  logic [3:0]  opc;
  logic [2:0]  cnd;
  logic        live;
  logic        is_br, is_jal, is_jr, is_hlt;
  logic        cond_ok, br_ready;
  logic        wait_br, wait_jr;
  logic        take_br, take_j, go;
  logic [15:0] br_tgt, jal_tgt;

  always_comb begin
    opc     = instr_q[15:12];
    cnd     = instr_q[11:9];
    live    = valid_q && (state_q != SQUASH)
              && (state_q != HALTED);
    is_br   = live && (opc == 4'hC);
    is_jal  = live && (opc == 4'hD);
    is_jr   = live && (opc == 4'hE);
    is_hlt  = live && (opc == 4'hF);
    br_tgt  = pc_q + 16'd1
              + {{7{instr_q[8]}}, instr_q[8:0]};
    jal_tgt = pc_q + 16'd1 + {4'h0, instr_q[11:0]};
    unique case (cnd)
      3'b000:  cond_ok = !zr;
      3'b001:  cond_ok = zr;
      3'b010:  cond_ok = !zr && !neg;
      3'b011:  cond_ok = neg;
      3'b100:  cond_ok = zr || !neg;
      3'b101:  cond_ok = neg || zr;
      3'b110:  cond_ok = ov;
      default: cond_ok = 1'b1;
    endcase
    // cond 111 is unconditional and never waits on flags
    br_ready = (cnd == 3'b111) || flags_valid;
    wait_br  = is_br && !br_ready;
    wait_jr  = is_jr && !jr_valid;
    take_br  = is_br && br_ready && cond_ok;
    take_j   = is_jal || (is_jr && jr_valid);
    go       = !rst && !stall_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (!stall_in) begin
      unique case (state_q)
        RUN, WAIT_FLAGS, WAIT_REG: begin
          if (wait_br) begin
            state_d = WAIT_FLAGS;
          end else if (wait_jr) begin
            state_d = WAIT_REG;
          end else if (is_hlt) begin
            state_d = HALTED;
            valid_d = 1'b0;
          end else begin
            instr_d = instr_in;
            pc_d    = pc_in;
            valid_d = !(take_br || take_j);
            state_d = (take_br || take_j) ? SQUASH : RUN;
          end
        end
        SQUASH: begin
          instr_d = instr_in;
          pc_d    = pc_in;
          valid_d = 1'b1;
          state_d = RUN;
        end
        HALTED: begin
          valid_d = 1'b0;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    instr_out   = instr_q;
    pc_out      = pc_q;
    valid_out   = valid_q;
    PCSrc       = go && take_br;
    takeJump    = go && take_j;
    bAddress    = PCSrc ? br_tgt : 16'h0000;
    jrValue     = '0;
    if (takeJump)
      jrValue = is_jal ? jal_tgt : jr_data;
    hlt         = !rst && ((state_q == HALTED)
                  || (go && is_hlt));
    fetch_stall = !rst && (stall_in || wait_br
                  || wait_jr || (state_q == HALTED));
  end

endmodule

// File: tb/tb_fetch_redirect.sv
// Directed and randomized bench for fetch_redirect with an
// instruction-level reference model.
module tb_fetch_redirect;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr_in, pc_in, jr_data;
  logic        stall_in, flags_valid, zr, neg, ov, jr_valid;
  logic [15:0] instr_out, pc_out, bAddress, jrValue;
  logic        valid_out, fetch_stall, PCSrc, takeJump, hlt;

  int vec_n  = 0;
  int miss_n = 0;

  always #5 clk = ~clk;

  fetch_redirect dut (
    .clk(clk), .rst(rst),
    .instr_in(instr_in), .pc_in(pc_in),
    .stall_in(stall_in), .flags_valid(flags_valid),
    .zr(zr), .neg(neg), .ov(ov),
    .jr_valid(jr_valid), .jr_data(jr_data),
    .instr_out(instr_out), .pc_out(pc_out),
    .valid_out(valid_out), .fetch_stall(fetch_stall),
    .PCSrc(PCSrc), .bAddress(bAddress),
    .takeJump(takeJump), .jrValue(jrValue), .hlt(hlt)
  );

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    vec_n++;
    assert (obs === exp) else begin
      miss_n++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic bit cond_holds(input int c, input bit z,
                                    input bit n, input bit v);
    case (c)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || !n;
      5: return n || z;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  // reference model: contents of the IF/ID slot and halt status
  logic [15:0] m_instr, m_pc;
  bit          m_valid, m_halt;

  initial begin
    rst = 1'b1;
    instr_in = 16'($urandom); pc_in = 16'($urandom);
    stall_in = 1'($urandom); flags_valid = 1'($urandom);
    zr = 1'($urandom); neg = 1'($urandom); ov = 1'($urandom);
    jr_valid = 1'($urandom); jr_data = 16'($urandom);
    tick();
    instr_in = 16'($urandom); jr_data = 16'($urandom);
    tick();
    settle();
    chk("rst_instr", instr_out, 16'h0);
    chk("rst_pc", pc_out, 16'h0);
    chk("rst_valid", 16'(valid_out), 16'h0);
    chk("rst_stall", 16'(fetch_stall), 16'h0);
    chk("rst_pcsrc", 16'(PCSrc), 16'h0);
    chk("rst_badr", bAddress, 16'h0);
    chk("rst_tj", 16'(takeJump), 16'h0);
    chk("rst_jv", jrValue, 16'h0);
    chk("rst_hlt", 16'(hlt), 16'h0);

    stall_in = 0; flags_valid = 1; zr = 0; neg = 0; ov = 0;
    jr_valid = 1; jr_data = 16'h0;
    instr_in = 16'hC3F0; pc_in = 16'h0010; zr = 1;
    rst = 1'b0;
    tick();
    settle();
    chk("tb_pcsrc", 16'(PCSrc), 16'h1);
    chk("tb_badr", bAddress, 16'h0001);
    chk("tb_tj", 16'(takeJump), 16'h0);
    chk("tb_stall", 16'(fetch_stall), 16'h0);
    instr_in = 16'h1111; pc_in = 16'h0011;
    tick();
    settle();
    chk("tb_squash", 16'(valid_out), 16'h0);
    chk("tb_sq_pcsrc", 16'(PCSrc), 16'h0);
    instr_in = 16'h2222; pc_in = 16'h0001;
    tick();
    settle();
    chk("tb_tgt_instr", instr_out, 16'h2222);
    chk("tb_tgt_pc", pc_out, 16'h0001);
    chk("tb_tgt_valid", 16'(valid_out), 16'h1);

    instr_in = 16'hC3F0; pc_in = 16'h0010;
    flags_valid = 0; zr = 0;
    tick();
    instr_in = 16'h3333; pc_in = 16'h0011;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("fw_stall", 16'(fetch_stall), 16'h1);
      chk("fw_hold", instr_out, 16'hC3F0);
      chk("fw_pcsrc", 16'(PCSrc), 16'h0);
      tick();
    end
    flags_valid = 1;
    settle();
    chk("fw_res_stall", 16'(fetch_stall), 16'h0);
    chk("fw_res_pcsrc", 16'(PCSrc), 16'h0);
    tick();
    settle();
    chk("fw_next_instr", instr_out, 16'h3333);
    chk("fw_next_valid", 16'(valid_out), 16'h1);

    instr_in = 16'hD020; pc_in = 16'hFFF0;
    tick();
    settle();
    chk("jal_tj", 16'(takeJump), 16'h1);
    chk("jal_jv", jrValue, 16'h0011);
    chk("jal_pcsrc", 16'(PCSrc), 16'h0);
    instr_in = 16'h4444; pc_in = 16'hFFF1;
    tick();
    settle();
    chk("jal_bubble", 16'(valid_out), 16'h0);
    instr_in = 16'h5555; pc_in = 16'h0011;
    tick();
    settle();
    chk("jal_tgt", instr_out, 16'h5555);
    chk("jal_tgt_v", 16'(valid_out), 16'h1);

    instr_in = 16'hE010; pc_in = 16'h0012; jr_valid = 0;
    tick();
    instr_in = 16'h6666; pc_in = 16'h0013;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("jr_stall", 16'(fetch_stall), 16'h1);
      chk("jr_tj_wait", 16'(takeJump), 16'h0);
      tick();
    end
    jr_valid = 1; jr_data = 16'h1234;
    settle();
    chk("jr_tj", 16'(takeJump), 16'h1);
    chk("jr_jv", jrValue, 16'h1234);
    chk("jr_stall_off", 16'(fetch_stall), 16'h0);
    tick();
    settle();
    chk("jr_bubble", 16'(valid_out), 16'h0);

    instr_in = 16'hF000; pc_in = 16'h0020;
    tick();
    settle();
    chk("hlt_out", 16'(hlt), 16'h1);
    chk("hlt_valid", 16'(valid_out), 16'h1);
    chk("hlt_instr", instr_out, 16'hF000);
    instr_in = 16'h7777; pc_in = 16'h0021;
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      chk("hlt_sticky", 16'(hlt), 16'h1);
      chk("hlt_valid0", 16'(valid_out), 16'h0);
      chk("hlt_stall", 16'(fetch_stall), 16'h1);
    end
    rst = 1;
    tick();
    rst = 0;
    settle();
    chk("hlt_rst", 16'(hlt), 16'h0);
    instr_in = 16'h8888; pc_in = 16'h0030;
    tick();
    settle();
    chk("resume_instr", instr_out, 16'h8888);
    chk("resume_valid", 16'(valid_out), 16'h1);

    rst = 1;
    tick();
    m_instr = 0; m_pc = 0; m_valid = 0; m_halt = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [3:0] op;
      logic [15:0] e_badr, e_jv;
      bit live, br, jal, jr, ht, wt, go;
      bit e_pcsrc, e_tj, e_hlt, e_fs;
      int c, imm, tgt;
      rst = ($urandom_range(0, 39) == 0);
      stall_in = ($urandom_range(0, 5) == 0);
      flags_valid = 1'($urandom); jr_valid = 1'($urandom);
      zr = 1'($urandom); neg = 1'($urandom); ov = 1'($urandom);
      jr_data = 16'($urandom); pc_in = 16'($urandom);
      instr_in = 16'($urandom);
      case ($urandom_range(0, 9))
        0, 1:    instr_in[15:12] = 4'hC;
        2:       instr_in[15:12] = 4'hD;
        3:       instr_in[15:12] = 4'hE;
        4: if ($urandom_range(0, 3) == 0) instr_in[15:12] = 4'hF;
        default: ;
      endcase
      op   = m_instr[15:12];
      c    = int'(m_instr[11:9]);
      live = m_valid && !m_halt;
      br   = live && op == 4'hC;
      jal  = live && op == 4'hD;
      jr   = live && op == 4'hE;
      ht   = live && op == 4'hF;
      wt   = (br && c != 7 && !flags_valid) || (jr && !jr_valid);
      go   = !rst && !stall_in && !wt;
      e_pcsrc = go && br && cond_holds(c, zr, neg, ov);
      e_tj = go && (jal || jr);
      imm  = int'(m_instr[8:0]);
      if (imm >= 256) imm -= 512;
      tgt  = (int'(m_pc) + 1 + imm) & 16'hFFFF;
      e_badr = e_pcsrc ? 16'(tgt) : 16'h0;
      tgt  = (int'(m_pc) + 1 + int'(m_instr[11:0])) & 16'hFFFF;
      e_jv = !e_tj ? 16'h0 : (jal ? 16'(tgt) : jr_data);
      e_hlt = !rst && (m_halt || (ht && !stall_in));
      e_fs = !rst && (m_halt || stall_in || wt);
      settle();
      chk("r_instr", instr_out, m_instr);
      chk("r_pc", pc_out, m_pc);
      chk("r_valid", 16'(valid_out), 16'(m_valid));
      chk("r_stall", 16'(fetch_stall), 16'(e_fs));
      chk("r_pcsrc", 16'(PCSrc), 16'(e_pcsrc));
      chk("r_badr", bAddress, e_badr);
      chk("r_tj", 16'(takeJump), 16'(e_tj));
      chk("r_jv", jrValue, e_jv);
      chk("r_hlt", 16'(hlt), 16'(e_hlt));
      chk("r_mutex", 16'(PCSrc && takeJump), 16'h0);
      if (rst) begin
        m_instr = 0; m_pc = 0; m_valid = 0; m_halt = 0;
      end else if (m_halt) begin
        m_valid = 0;
      end else if (stall_in || wt) begin
      end else if (ht) begin
        m_halt = 1; m_valid = 0;
      end else begin
        m_instr = instr_in; m_pc = pc_in;
        m_valid = !(e_pcsrc || e_tj);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_n, miss_n);
    $finish;
  end

endmodule
